// File: rtl/fifo_buffer_acc_pkg.sv
// Shared definitions for the accumulator partial-sum FIFO: default geometry
// and the per-cycle operation encoding used to steer the occupancy counter.
package fifo_buffer_acc_pkg;

   localparam int DefDataWidth   = 32;
   localparam int DefBufferWidth = 2;
   localparam int DefBufferSize  = 4;

   // What the FIFO does on a given edge, from the accepted push/pop strobes.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e decode_op(input logic do_push, input logic do_pop);
      return fifo_op_e'({do_pop, do_push});
   endfunction

endpackage

// File: rtl/fifo_buffer_acc_if.sv
// Producer/consumer bus of the accumulator FIFO. The master drives the
// push/pop requests and write data; the slave (the FIFO) returns the flags
// and the registered read word.
interface fifo_buffer_acc_if
   import fifo_buffer_acc_pkg::*;
#(
   parameter int DataWidth = DefDataWidth
);

   logic                 Push;
   logic                 Pop;
   logic [DataWidth-1:0] DataIn;
   logic                 Empty;
   logic                 Full;
   logic [DataWidth-1:0] DataOut;

   modport master (
      output Push,
      output Pop,
      output DataIn,
      input  Empty,
      input  Full,
      input  DataOut
   );

   modport slave (
      input  Push,
      input  Pop,
      input  DataIn,
      output Empty,
      output Full,
      output DataOut
   );

endinterface

// File: rtl/fifo_buffer_acc_mem.sv
// One-write/one-read register array backing the FIFO. Writes land on the
// rising edge; the read port is combinational so the top level can capture
// the addressed word into its own output register in the same cycle.
module fifo_buffer_acc_mem
   import fifo_buffer_acc_pkg::*;
#(
   parameter int DataWidth = DefDataWidth,
   parameter int AddrWidth = DefBufferWidth,
   parameter int Depth     = DefBufferSize
) (
   input  logic                 clk,
   input  logic                 wr_en_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [DataWidth-1:0] wr_data_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   output logic [DataWidth-1:0] rd_data_o
);

   // Contents are deliberately not reset: stale words are never visible
   // because the pointers and count gate every read.
   logic [DataWidth-1:0] mem_q [Depth];

   // Store the incoming word at the write address when enabled.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_buffer_acc.sv
// Single-clock FIFO queueing accumulator partial sums. Holds the read/write
// pointers, occupancy count, registered Empty/Full flags and the DataOut
// register; the storage itself lives in fifo_buffer_acc_mem.
module fifo_buffer_acc
   import fifo_buffer_acc_pkg::*;
#(
   parameter int DataWidth   = DefDataWidth,
   parameter int BufferWidth = DefBufferWidth,
   parameter int BufferSize  = DefBufferSize
) (
   input  logic               clk,
   input  logic               aclr,
   fifo_buffer_acc_if.slave   bus
);

   localparam int                    CntWidth = BufferWidth + 1;
   localparam logic [CntWidth-1:0]   CntFull  = CntWidth'(BufferSize);
   localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);

   logic [BufferWidth-1:0] wr_ptr_q,   wr_ptr_d;
   logic [BufferWidth-1:0] rd_ptr_q,   rd_ptr_d;
   logic [CntWidth-1:0]    count_q,    count_d;
   logic [DataWidth-1:0]   data_out_q, data_out_d;
   logic                   empty_q,    empty_d;
   logic                   full_q,     full_d;

   logic                   do_push;
   logic                   do_pop;
   logic [DataWidth-1:0]   mem_rd_data;
   fifo_op_e               op;

   // A pop only succeeds with data present; a push into a full FIFO only
   // succeeds when a simultaneous pop frees the oldest slot. Because pop is
   // gated by Empty, push+pop on an empty FIFO never bypasses.
   assign do_pop  = bus.Pop & ~empty_q;
   assign do_push = bus.Push & (~full_q | do_pop);
   assign op      = decode_op(do_push, do_pop);

   fifo_buffer_acc_mem #(
      .DataWidth (DataWidth),
      .AddrWidth (BufferWidth),
      .Depth     (BufferSize)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (do_push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.DataIn),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (mem_rd_data)
   );

   // Next-state for pointers, occupancy, flags and the output word.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;

      if (do_push) begin
         wr_ptr_d = BufferWidth'(wr_ptr_q + 1'b1);
      end
      if (do_pop) begin
         rd_ptr_d   = BufferWidth'(rd_ptr_q + 1'b1);
         data_out_d = mem_rd_data;
      end

      case (op)
         OP_PUSH: count_d = count_q + CntOne;
         OP_POP:  count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      // Flags are registered from the next count so they change cleanly
      // on the same edge as the count itself.
      empty_d = (count_d == '0);
      full_d  = (count_d == CntFull);
   end

   // State update; reset discards all queued data but leaves storage as is.
   always_ff @(posedge clk) begin
      if (aclr) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
      end
   end

   assign bus.DataOut = data_out_q;
   assign bus.Empty   = empty_q;
   assign bus.Full    = full_q;

endmodule

// File: tb/tb_fifo_buffer_acc.sv
// Scoreboard bench for fifo_buffer_acc: the driver applies one input set per
// cycle, evaluates a queue-based reference model and posts the expected
// outputs after the edge; a monitor compares on the falling edge.
module tb_fifo_buffer_acc;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic aclr;

   always #5 clk = ~clk;

   fifo_buffer_acc_if #(.DataWidth(DW)) bus ();

   fifo_buffer_acc #(
      .DataWidth   (DW),
      .BufferWidth (2),
      .BufferSize  (DEPTH)
   ) dut (
      .clk  (clk),
      .aclr (aclr),
      .bus  (bus)
   );

   typedef struct {
      logic [DW-1:0] dout;
      logic          empty;
      logic          full;
      bit            popped;
      int            cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_dout = '0;
   int            checks = 0;
   int            passed = 0;
   int            cyc = 0;
   int            data_ctr = 100;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] expv, input int c);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
   endtask

   // One clock of stimulus plus the reference model's view of that edge.
   task automatic cycle(input logic r, input logic p, input logic o, input logic [DW-1:0] d);
      exp_t e;
      bit   dp;
      bit   dps;
      aclr       = r;
      bus.Push   = p;
      bus.Pop    = o;
      bus.DataIn = d;
      e.popped   = 1'b0;
      if (r) begin
         model_q.delete();
         model_dout = '0;
      end else begin
         dp  = o && (model_q.size() > 0);
         dps = p && ((model_q.size() < DEPTH) || dp);
         if (dp) begin
            model_dout = model_q.pop_front();
            e.popped   = 1'b1;
         end
         if (dps) model_q.push_back(d);
      end
      e.dout  = model_dout;
      e.empty = (model_q.size() == 0);
      e.full  = (model_q.size() == DEPTH);
      e.cyc   = cyc;
      @(posedge clk);
      exp_q.push_back(e);
      cyc++;
      #1;
   endtask

   // Monitor: compare every posted expectation half a cycle after its edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("DataOut", bus.DataOut, e.dout, e.cyc);
            chk("Empty", {{(DW-1){1'b0}}, bus.Empty}, {{(DW-1){1'b0}}, e.empty}, e.cyc);
            chk("Full", {{(DW-1){1'b0}}, bus.Full}, {{(DW-1){1'b0}}, e.full}, e.cyc);
            if (e.popped) $display("cycle %0d pop DataOut=%h expected %h", e.cyc, bus.DataOut, e.dout);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aclr       = 1'b1;
      bus.Push   = 1'b0;
      bus.Pop    = 1'b0;
      bus.DataIn = '0;

      // Reset, then reset with three words queued followed by ignored pops.
      cycle(1, 0, 0, 0);
      for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 32'(10 + i));
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);

      // Fill to full, then an overflow push that must be dropped.
      for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 32'(i));
      cycle(0, 1, 0, 5);

      // Drain plus one pop on empty; then two idle cycles.
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      // Push+pop on empty: push only.
      cycle(0, 1, 1, 7);
      cycle(0, 0, 1, 0);

      // Push+pop on full holding 1..4 with 9 entering.
      for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 32'(i));
      cycle(0, 1, 1, 9);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

      // Wrap: ten rounds of push-2/pop-2.
      for (int r = 0; r < 10; r++) begin
         cycle(0, 1, 0, 32'(data_ctr)); data_ctr++;
         cycle(0, 1, 0, 32'(data_ctr)); data_ctr++;
         cycle(0, 0, 1, 0);
         cycle(0, 0, 1, 0);
      end

      // Randomized traffic with occasional mid-stream resets.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
               DW'($urandom));
      end

      cycle(0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
